// File: rtl/bus_pkg.sv
// Shared definitions for the core-to-memory/GPIO bus arbiter.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RELEASE} state_t;

  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 8;
  localparam int GPIO_SEL_BIT = 8;
  localparam logic RW_WRITE   = 1'b1;
  localparam logic RW_READ    = 1'b0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_winner
);
  always_comb begin
    o_any    = |i_req;
    o_winner = '0;
    // Scan farthest-first so the nearest requester after i_ptr overwrites last.
    for (int i = N; i >= 1; i--) begin
      if (i_req[(int'(i_ptr) + i) % N])
        o_winner = IW'((int'(i_ptr) + i) % N);
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus controller: one RAM or GPIO access at a time,
// completed by a single-cycle grant_given pulse to the owning core.
module bus_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = bus_pkg::ADDR_W,
  parameter int DATA_W    = bus_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        grant_request,
  input  logic [NUM_CORES-1:0]        rw,
  input  logic [NUM_CORES*ADDR_W-1:0] address,
  input  logic [NUM_CORES*DATA_W-1:0] data_out,
  output logic [NUM_CORES-1:0]        grant_given,
  output logic [DATA_W-1:0]           data_in,
  output logic [7:0]                  mem_addr,
  output logic                        mem_we,
  output logic [7:0]                  mem_wdata,
  input  logic [7:0]                  mem_rdata,
  output logic [7:0]                  gpio_out,
  input  logic [7:0]                  gpio_in
);
  import bus_pkg::*;

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t            r_state, w_next;
  logic [IW-1:0]     r_owner, r_rr_ptr, w_winner;
  logic              r_rw, r_gpio_sel, w_any;
  logic [7:0]        r_gpio_s1, r_gpio_s2;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_rw;

  rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_rr (
    .i_req    (grant_request),
    .i_ptr    (r_rr_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_sel_addr = address[int'(w_winner)*ADDR_W +: ADDR_W];
  assign w_sel_data = data_out[int'(w_winner)*DATA_W +: DATA_W];
  assign w_sel_rw   = rw[w_winner];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Requests are only sampled in IDLE; RELEASE gives the owner a cycle to drop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  w_next = WAIT;
      WAIT:    w_next = RELEASE;
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_given <= '0;
      data_in     <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      gpio_out    <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= IW'(NUM_CORES - 1);
      r_rw        <= RW_READ;
      r_gpio_sel  <= 1'b0;
      r_gpio_s1   <= '0;
      r_gpio_s2   <= '0;
    end else begin
      r_gpio_s1   <= gpio_in;
      r_gpio_s2   <= r_gpio_s1;
      mem_we      <= 1'b0;
      grant_given <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_owner    <= w_winner;
          r_rr_ptr   <= w_winner;
          r_rw       <= w_sel_rw;
          r_gpio_sel <= w_sel_addr[GPIO_SEL_BIT];
          mem_addr   <= w_sel_addr[7:0];
          mem_wdata  <= w_sel_data;
          mem_we     <= (w_sel_rw == RW_WRITE) && !w_sel_addr[GPIO_SEL_BIT];
          if ((w_sel_rw == RW_WRITE) && w_sel_addr[GPIO_SEL_BIT])
            gpio_out <= w_sel_data;
        end
        WAIT: begin
          // RAM data is valid here: address was sampled on the ACCESS edge.
          if (r_rw == RW_WRITE) data_in <= '0;
          else if (r_gpio_sel)  data_in <= r_gpio_s2;
          else                  data_in <= mem_rdata;
          grant_given[r_owner] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
